data_bus_unit: RTL

Data-side memory stage of the single-cycle RISC-V core: it consumes the core's `memwrite`, `o_alu_result` (address) and `o_write_data`, and returns `read_data` in the same cycle. It holds the word-wide data RAM plus three memory-mapped registers: a free-running cycle counter, a transmit FIFO drained through a valid/ready port, and a status register. It replaces the behavioural data memory used around the core in simulation.

---
 rtl/dbu_pkg.sv | 33 +++
 rtl/tx_fifo.sv | 48 ++++
 rtl/data_bus_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/dbu_pkg.sv
// Shared constants for the data bus unit: MMIO decode, register offsets and STATUS layout.
package dbu_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
    localparam logic [31:0] MMIO_MASK = 32'h8000_0000;

    localparam logic [1:0] OFF_CYCLE  = 2'd0;
    localparam logic [1:0] OFF_TXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;

    localparam int unsigned ST_EMPTY   = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVF     = 2;
    localparam int unsigned ST_CNT_LSB = 4;
    localparam int unsigned ST_CNT_W   = 4;

    // Packs the FIFO flags and occupancy into the STATUS read value.
    function automatic logic [31:0] status_word(
        input logic                empty,
        input logic                full,
        input logic                ovf,
        input logic [ST_CNT_W-1:0] cnt
    );
        logic [31:0] w;
        w = '0;
        w[ST_EMPTY] = empty;
        w[ST_FULL]  = full;
        w[ST_OVF]   = ovf;
        w[ST_CNT_LSB +: ST_CNT_W] = cnt;
        return w;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with first-word fall-through head; pointers and count wrap at powers of two.
module tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    output logic                    full,
    input  logic                    pop,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic [WIDTH-1:0]        head
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero when empty so stale storage never leaks out after reset.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/data_bus_unit.sv
// Data-side memory stage: word RAM with async read plus CYCLE, TXDATA and STATUS registers.
module data_bus_unit
    import dbu_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 256,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] read_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   cycle_cnt;
    logic          overflow;
    logic          is_mmio;
    logic [1:0]    offset;
    logic [AW-1:0] word_idx;
    logic          ram_we;
    logic          cyc_wr;
    logic          push;
    logic          stat_wr;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_addr;

    // Only the word-index bits select RAM; everything else aliases.
    assign is_mmio     = ((addr & MMIO_MASK) == MMIO_BASE);
    assign offset      = addr[3:2];
    assign word_idx    = addr[AW+1:2];
    assign unused_addr = ^{addr[30:AW+2], addr[1:0]};

    assign ram_we  = memwrite && !is_mmio;
    assign cyc_wr  = memwrite && is_mmio && (offset == OFF_CYCLE);
    assign push    = memwrite && is_mmio && (offset == OFF_TXDATA);
    assign stat_wr = memwrite && is_mmio && (offset == OFF_STATUS);

    assign tx_valid = !fifo_empty;
    assign pop      = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (ram_we) ram[word_idx] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       cycle_cnt <= '0;
        else if (cyc_wr) cycle_cnt <= '0;
        else             cycle_cnt <= cycle_cnt + 32'd1;
    end

    // A dropped push and a clear in the same cycle leave overflow set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          overflow <= 1'b0;
        else if (push && fifo_full)         overflow <= 1'b1;
        else if (stat_wr && wdata[ST_OVF])  overflow <= 1'b0;
    end

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (wdata[7:0]),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (tx_data)
    );

    always_comb begin
        read_data = '0;
        if (!is_mmio) begin
            read_data = ram[word_idx];
        end else begin
            case (offset)
                OFF_CYCLE:  read_data = cycle_cnt;
                OFF_STATUS: read_data = status_word(fifo_empty, fifo_full, overflow,
                                                    ST_CNT_W'(fifo_count));
                default:    read_data = '0;
            endcase
        end
    end

endmodule
